// File: rtl/spi_controller_if.sv
// ============================================================================
// Module      : spi_controller_if
// Description : Request handshake and SPI pin bundle for spi_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_controller_if;
    logic       valid;
    logic       ready;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       nCS;
    logic       SCLK;
    logic       COPI;

    // Requester side: issues frames and observes the SPI pins
    modport master (
        output valid, wr, addr, data,
        input  ready, busy, done, nCS, SCLK, COPI
    );

    // Controller side
    modport slave (
        input  valid, wr, addr, data,
        output ready, busy, done, nCS, SCLK, COPI
    );
endinterface

`default_nettype wire

// File: rtl/spi_controller.sv
// ============================================================================
// Module      : spi_controller
// Description : 16-bit write-only SPI mode-0 master, {wr, addr[6:0], data[7:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_controller #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned CS_SETUP    = 4,
    parameter int unsigned CS_GAP      = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] c_setup_last = 8'(CS_SETUP - 1);
    localparam logic [7:0] c_half_last  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] c_gap_last   = 8'(CS_GAP - 1);
    localparam logic [4:0] c_last_bit   = 5'd15;

    state_t      r_state;
    logic [7:0]  r_phase;
    logic [4:0]  r_bit;
    logic [15:0] r_shift;
    logic        r_ncs;
    logic        r_sclk;
    logic        r_copi;
    logic        r_done;

    state_t      w_state_nxt;
    logic [7:0]  w_phase_nxt;
    logic [4:0]  w_bit_nxt;
    logic [15:0] w_shift_nxt;
    logic        w_ncs_nxt;
    logic        w_sclk_nxt;
    logic        w_copi_nxt;
    logic        w_done_nxt;
    logic        w_ready;
    logic        w_handshake;

    assign w_ready     = (r_state == S_IDLE) && !rst;
    assign w_handshake = bus.valid && w_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + 8'd1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_ncs_nxt   = r_ncs;
        w_sclk_nxt  = r_sclk;
        w_copi_nxt  = r_copi;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_phase_nxt = 8'd0;
                w_bit_nxt   = 5'd0;
                if (w_handshake) begin
                    w_state_nxt = S_SETUP;
                    w_shift_nxt = {bus.wr, bus.addr, bus.data};
                    w_ncs_nxt   = 1'b0;
                    w_sclk_nxt  = 1'b0;
                    w_copi_nxt  = bus.wr;
                end
            end

            S_SETUP: begin
                if (r_phase == c_setup_last) begin
                    w_state_nxt = S_SHIFT;
                    w_phase_nxt = 8'd0;
                    w_sclk_nxt  = 1'b1;
                end
            end

            S_SHIFT: begin
                if (r_phase == c_half_last) begin
                    w_phase_nxt = 8'd0;
                    if (r_sclk) begin
                        w_sclk_nxt = 1'b0;
                        if (r_bit == c_last_bit) begin
                            w_state_nxt = S_HOLD;
                        end else begin
                            // Next bit is launched on the falling edge so it is
                            // settled for the whole following high phase.
                            w_copi_nxt  = r_shift[14];
                            w_shift_nxt = {r_shift[14:0], 1'b0};
                            w_bit_nxt   = r_bit + 5'd1;
                        end
                    end else begin
                        w_sclk_nxt = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (r_phase == c_half_last) begin
                    w_state_nxt = S_GAP;
                    w_phase_nxt = 8'd0;
                    w_ncs_nxt   = 1'b1;
                    w_copi_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end

            S_GAP: begin
                if (r_phase == c_gap_last) begin
                    w_state_nxt = S_IDLE;
                    w_phase_nxt = 8'd0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = 8'd0;
                w_bit_nxt   = 5'd0;
                w_ncs_nxt   = 1'b1;
                w_sclk_nxt  = 1'b0;
                w_copi_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_phase <= 8'd0;
            r_bit   <= 5'd0;
            r_shift <= 16'd0;
            r_ncs   <= 1'b1;
            r_sclk  <= 1'b0;
            r_copi  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_ncs   <= w_ncs_nxt;
            r_sclk  <= w_sclk_nxt;
            r_copi  <= w_copi_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Pins come straight from flops; only the handshake status is decoded.
    assign bus.nCS   = r_ncs;
    assign bus.SCLK  = r_sclk;
    assign bus.COPI  = r_copi;
    assign bus.done  = r_done;
    assign bus.ready = w_ready;
    assign bus.busy  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter HALF_PERIOD, default 4, clk cycles per SCLK high phase and per SCLK low phase; legal range 2..255.
REQ-002 Parameter CS_SETUP, default 4, clk cycles nCS is low with SCLK low before the first SCLK rise; legal range 1..255.
REQ-003 Parameter CS_GAP, default 8, minimum clk cycles nCS stays high between frames; legal range 1..255.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 valid  input  1  request to send one frame.
REQ-007 ready  output  1  controller idle and accepting a request.
REQ-008 wr  input  1  frame bit 15 (1 = write).
REQ-009 addr  input  7  frame bits 14:8.
REQ-010 data  input  8  frame bits 7:0.
REQ-011 busy  output  1  frame in progress (any state other than IDLE).
REQ-012 done  output  1  one-cycle pulse at frame completion.
REQ-013 nCS  output  1  active-low chip select.
REQ-014 SCLK  output  1  SPI clock, mode 0 (idle low).
REQ-015 COPI  output  1  serial data, MSB first.

Function
REQ-016 nCS, SCLK and COPI shall be driven directly from flops (no combinational path to the pins).
REQ-017 ready shall equal (state == IDLE) and not rst; a handshake occurs on any cycle with valid and ready both high.
REQ-018 On handshake the block shall latch frame = {wr, addr, data}; later changes to the inputs do not affect the frame in flight.
REQ-019 States: IDLE, SETUP, SHIFT, HOLD, GAP; one shared 8-bit phase counter and a 5-bit bit counter.
REQ-020 IDLE: nCS=1, SCLK=0; on handshake go to SETUP, nCS=0 and COPI=frame[15] from the next cycle.
REQ-021 SETUP: hold for CS_SETUP cycles, then go to SHIFT with SCLK=1.
REQ-022 SHIFT: each of 16 bits has SCLK high for HALF_PERIOD cycles; bits 0..14 are followed by SCLK low for HALF_PERIOD cycles.
REQ-023 COPI shall change only on the cycle where SCLK goes high to low, to the next frame bit, so it is stable for the whole high phase.
REQ-024 After the 16th high phase, SCLK shall go low and the state shall go to HOLD; COPI holds frame[0].
REQ-025 HOLD: nCS low, SCLK low for HALF_PERIOD cycles; then nCS=1, COPI=0, state GAP.
REQ-026 done shall be high for exactly the first cycle in which nCS is high again.
REQ-027 nCS low time per frame shall be exactly CS_SETUP + 32*HALF_PERIOD cycles, which is 132 at defaults; exactly 16 SCLK rising edges per frame.
REQ-028 GAP: stay for CS_GAP cycles, then go to IDLE; the next nCS fall shall occur no sooner than CS_GAP+1 cycles after the previous nCS rise.
REQ-029 valid while busy shall be ignored; requests are not queued.
REQ-030 SCLK shall never toggle while nCS is high.

Reset
REQ-031 While rst is high, on each clk edge: state=IDLE, nCS=1, SCLK=0, COPI=0, done=0, busy=0, counters=0; ready=0.
REQ-032 rst asserted mid-frame shall abort the frame: nCS=1 and SCLK=0 on the next edge, no done pulse, no partial bits sent afterwards.
REQ-033 ready shall be 1 on the first cycle after rst falls.

Verification
REQ-034 wr=1, addr=0x00, data=0xA5 -> COPI sampled at the 16 SCLK rises = 1000_0000_1010_0101; nCS low for 132 cycles; one done pulse.
REQ-035 wr=1, addr=0x04, data=0x80 into a mode-0 16-bit sampler model -> the model captures 0x8480 exactly once.
REQ-036 valid held high with two queued frames (0x0112, 0x0234) -> both are sent in order, nCS high gap >= 9 cycles, and two done pulses.
REQ-037 Second valid pulsed during SHIFT -> ignored; only the first frame appears on COPI, and ready stays 0 until GAP ends.
REQ-038 rst pulsed after the 5th SCLK rise -> nCS=1 and SCLK=0 on the next edge, no done, and ready=1 the cycle after rst falls.
REQ-039 wr=0, addr=0x7F, data=0xFF -> bits 0111_1111_1111_1111; SCLK stays low throughout SETUP, HOLD and GAP.
